pci_target_cmd_tracker: RTL

Parametrised PCI target command decoder and transaction tracker for the slave.
- Samples FRAME#, C/BE# and AD in the address phase and decodes the full read/write command set.
- Compares the address against one BAR window and claims hits with DEVSEL#.
- Drives TRDY#/STOP# through the data phases, tracking burst address and data-phase count until the last transfer.
- Sits between the PCI pins and the slave's data-path/memory block.

---
 rtl/pci_pkg.sv | 24 ++
 rtl/pci_cmd_decode.sv | 35 +++
 rtl/pci_target_cmd_tracker.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/pci_pkg.sv
// Shared PCI command codes, rw encoding and tracker state encoding.
package pci_pkg;

  localparam logic [3:0] CMD_IO_RD  = 4'b0010;
  localparam logic [3:0] CMD_IO_WR  = 4'b0011;
  localparam logic [3:0] CMD_MEM_RD = 4'b0110;
  localparam logic [3:0] CMD_MEM_WR = 4'b0111;
  localparam logic [3:0] CMD_MRM    = 4'b1100;
  localparam logic [3:0] CMD_MRL    = 4'b1110;
  localparam logic [3:0] CMD_MWI    = 4'b1111;

  localparam logic [1:0] RW_IDLE  = 2'b00;
  localparam logic [1:0] RW_READ  = 2'b01;
  localparam logic [1:0] RW_WRITE = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLAIM  = 3'd1,
    DATA   = 3'd2,
    TURN   = 3'd3,
    IGNORE = 3'd4
  } state_t;

endpackage

// File: rtl/pci_cmd_decode.sv
// Combinational address-phase decode: command class and BAR window hit.
module pci_cmd_decode
  import pci_pkg::*;
#(
  parameter int              ADDR_W        = 32,
  parameter logic [ADDR_W-1:0] BAR_BASE    = 32'h0000_1000,
  parameter int              BAR_SIZE_LOG2 = 8,
  parameter int              ENABLE_IO     = 0
) (
  input  logic [ADDR_W-1:0] ad,
  input  logic [3:0]        cbe_n,
  output logic [1:0]        rw_class,
  output logic              hit
);

  logic in_window;
  logic unused_low;

  always_comb begin
    rw_class = RW_IDLE;
    case (cbe_n)
      CMD_MEM_RD, CMD_MRM, CMD_MRL: rw_class = RW_READ;
      CMD_MEM_WR, CMD_MWI:          rw_class = RW_WRITE;
      CMD_IO_RD:  rw_class = (ENABLE_IO != 0) ? RW_READ  : RW_IDLE;
      CMD_IO_WR:  rw_class = (ENABLE_IO != 0) ? RW_WRITE : RW_IDLE;
      default:    rw_class = RW_IDLE;
    endcase
  end

  assign in_window  = (ad[ADDR_W-1:BAR_SIZE_LOG2] == BAR_BASE[ADDR_W-1:BAR_SIZE_LOG2]);
  assign hit        = (rw_class != RW_IDLE) && in_window;
  // Offset bits inside the window do not take part in the compare.
  assign unused_low = ^ad[BAR_SIZE_LOG2-1:0];

endmodule

// File: rtl/pci_target_cmd_tracker.sv
// PCI target command tracker: claims BAR hits, paces data phases, counts transfers.
//
// state  | meaning
// IDLE   | waiting for an address phase
// CLAIM  | hit decoded, DEVSEL# asserted, rw valid
// DATA   | data phases; TRDY# follows target_ready, STOP# at window edge
// TURN   | bus turnaround, all outputs released
// IGNORE | miss, wait for master to finish the transaction
module pci_target_cmd_tracker
  import pci_pkg::*;
#(
  parameter int                ADDR_W        = 32,
  parameter logic [ADDR_W-1:0] BAR_BASE      = 32'h0000_1000,
  parameter int                BAR_SIZE_LOG2 = 8,
  parameter int                CNT_W         = 8,
  parameter int                ENABLE_IO     = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_n,
  input  logic              irdy_n,
  input  logic [ADDR_W-1:0] ad,
  input  logic [3:0]        cbe_n,
  input  logic              target_ready,
  output logic              devsel_n,
  output logic              trdy_n,
  output logic              stop_n,
  output logic [1:0]        rw,
  output logic [3:0]        cmd,
  output logic [ADDR_W-1:0] addr,
  output logic              xfer,
  output logic [CNT_W-1:0]  phase_cnt,
  output logic              busy
);

  state_t            state_q, state_d;
  logic              frame_q;
  logic              hold_q, hold_d;
  logic [1:0]        rw_q;
  logic [3:0]        cmd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              xfer_q;

  logic [1:0]        rw_class;
  logic              hit;
  logic              addr_phase;
  logic              in_data;
  logic              claimed;
  logic              transfer;
  logic              at_bnd;
  logic [ADDR_W-1:0] addr_next;

  pci_cmd_decode #(
    .ADDR_W        (ADDR_W),
    .BAR_BASE      (BAR_BASE),
    .BAR_SIZE_LOG2 (BAR_SIZE_LOG2),
    .ENABLE_IO     (ENABLE_IO)
  ) u_decode (
    .ad       (ad),
    .cbe_n    (cbe_n),
    .rw_class (rw_class),
    .hit      (hit)
  );

  assign addr_phase = (state_q == IDLE) && !frame_n && frame_q && irdy_n;
  assign in_data    = (state_q == DATA);
  assign claimed    = (state_q == CLAIM) || in_data;
  assign addr_next  = addr_q + ADDR_W'(4);
  // The next word would fall outside the BAR window: disconnect with this one.
  assign at_bnd     = (addr_next[ADDR_W-1:BAR_SIZE_LOG2] != addr_q[ADDR_W-1:BAR_SIZE_LOG2]);

  assign devsel_n  = !claimed;
  assign trdy_n    = !(in_data && !hold_q && target_ready);
  assign stop_n    = !(in_data && (hold_q || (at_bnd && target_ready)));
  assign rw        = claimed ? rw_q : RW_IDLE;
  assign busy      = claimed || (state_q == IGNORE);
  assign transfer  = in_data && !irdy_n && !trdy_n;

  assign cmd       = cmd_q;
  assign addr      = addr_q;
  assign xfer      = xfer_q;
  assign phase_cnt = cnt_q;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (addr_phase) state_d = hit ? CLAIM : IGNORE;
      end
      CLAIM: begin
        state_d = DATA;
        hold_d  = 1'b0;
      end
      DATA: begin
        if (hold_q) begin
          if (frame_n) state_d = TURN;
        end else if (transfer) begin
          if (frame_n)     state_d = TURN;
          else if (at_bnd) hold_d  = 1'b1;
        end else if (frame_n && irdy_n) begin
          state_d = TURN;
        end
      end
      TURN: begin
        state_d = IDLE;
        hold_d  = 1'b0;
      end
      IGNORE: begin
        if (frame_n && irdy_n) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        hold_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= 1'b0;
      frame_q <= 1'b1;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      frame_q <= frame_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rw_q   <= RW_IDLE;
      cmd_q  <= 4'h0;
      addr_q <= '0;
      cnt_q  <= '0;
      xfer_q <= 1'b0;
    end else begin
      xfer_q <= transfer;
      if (addr_phase) begin
        rw_q   <= rw_class;
        cmd_q  <= cbe_n;
        addr_q <= {ad[ADDR_W-1:2], 2'b00};
        cnt_q  <= '0;
      end else if (transfer) begin
        addr_q <= addr_next;
        if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule
